// File: rtl/adc_spi_sampler_if.sv
// Signal bundle between the ADC sampler and its surroundings: control inputs,
// the SPI pins of the current-sense ADC, and the published sample stream.
// Sample stream protocol: adc_data_valid is a one-cycle pulse with no ready
// (no back-pressure); adc_data_value is stable from the pulse onward and holds
// until the next pulse. Pulses are always separated by at least one low cycle.
interface adc_spi_sampler_if;
    logic        enable;
    logic        clear_overrun;
    logic        adc_miso;
    logic        adc_csn;
    logic        adc_sclk;
    logic        adc_data_valid;
    logic [15:0] adc_data_value;
    logic        adc_overrun;
    logic [15:0] sample_count;

    // Sampler side.
    modport master (
        input  enable, clear_overrun, adc_miso,
        output adc_csn, adc_sclk, adc_data_valid, adc_data_value,
               adc_overrun, sample_count
    );

    // Consumer / ADC side.
    modport slave (
        output enable, clear_overrun, adc_miso,
        input  adc_csn, adc_sclk, adc_data_valid, adc_data_value,
               adc_overrun, sample_count
    );
endinterface

// File: rtl/adc_spi_sampler.sv
// Periodic SPI sampler for a 16-bit current-sense ADC. A free-running period
// counter starts one frame per tick; the frame is shifted in MSB first and
// published with an isolated one-cycle valid pulse. Ticks that arrive while a
// frame is in flight are dropped and flagged on the sticky overrun bit.
module adc_spi_sampler #(
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned SAMPLE_PERIOD = 100,
    parameter int unsigned CS_SETUP      = 2,
    parameter int unsigned CS_HOLD       = 2,
    parameter int unsigned FRAME_BITS    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    adc_spi_sampler_if.master     bus,
    output logic [2:0]            state_dbg_o
);
    localparam int unsigned PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned BW = $clog2(FRAME_BITS + 1);

    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [15:0]   SETUP_LAST  = 16'(CS_SETUP - 1);
    localparam logic [15:0]   DIV_LAST    = 16'(CLK_DIV - 1);
    localparam logic [15:0]   HOLD_LAST   = 16'(CS_HOLD - 1);
    localparam logic [BW-1:0] BITS_ALL    = BW'(FRAME_BITS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SHIFT   = 3'd2,
        HOLD    = 3'd3,
        PUBLISH = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [BW-1:0] bits_q, bits_d;
    logic          sclk_q, sclk_d;
    logic [15:0]   shift_q, shift_d;
    logic [15:0]   data_q, data_d;
    logic [15:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          tick;

    // Sample cadence: counter parked at 0 while disabled, wraps on the tick.
    always_comb begin
        tick     = bus.enable && (period_q == PERIOD_LAST);
        period_d = period_q + PW'(1);
        if (!bus.enable || tick) begin
            period_d = '0;
        end
    end

    // Frame sequencer: chip-select setup, SCLK generation and shifting,
    // chip-select hold, then a single publish cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        sclk_d  = sclk_q;
        shift_d = shift_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                if (tick) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    bits_d  = '0;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: the ADC has held this bit since the last fall.
                        shift_d = {shift_q[14:0], bus.adc_miso};
                        bits_d  = bits_q + BW'(1);
                    end else if (bits_q == BITS_ALL) begin
                        // Final falling edge ends the frame with SCLK low.
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = PUBLISH;
                    cnt_d   = '0;
                    data_d  = shift_q;
                    count_d = count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PUBLISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sclk_d  = 1'b0;
            end
        endcase
    end

    // Sticky overrun: a tick while busy sets it and beats a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q;
        if (tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (bus.clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // State registers; reset abandons any frame in flight without publishing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            period_q  <= '0;
            cnt_q     <= '0;
            bits_q    <= '0;
            sclk_q    <= 1'b0;
            shift_q   <= '0;
            data_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            bits_q    <= bits_d;
            sclk_q    <= sclk_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Chip select and valid are decoded from the state register, so both
    // return to idle levels the instant reset asserts.
    assign bus.adc_csn        = !((state_q == SETUP) || (state_q == SHIFT));
    assign bus.adc_sclk       = sclk_q;
    assign bus.adc_data_valid = (state_q == PUBLISH);
    assign bus.adc_data_value = data_q;
    assign bus.adc_overrun    = overrun_q;
    assign bus.sample_count   = count_q;
    assign state_dbg_o        = state_q;
endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
- Upstream stage of the peak-current checker: drives a 16-bit SPI current-sense ADC on a fixed sample cadence.
- Deserialises each frame and presents it as adc_data_value with a one-cycle adc_data_valid pulse.
- The checker detects valid by rising edge, so every valid pulse is isolated, with at least one low cycle before and after.

Parameters:
- CLK_DIV, 2: SCLK half-period in clk cycles (>=1)
- SAMPLE_PERIOD, 100: clk cycles between conversion starts (>=2)
- CS_SETUP, 2: cycles from adc_csn falling to first SCLK edge (>=1)
- CS_HOLD, 2: cycles adc_csn held high after the last SCLK edge, before data is published (>=1)
- FRAME_BITS, 16: SCLK rising edges per frame; data MSB first

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  1 = periodic sampling runs
- clear_overrun  in  1  clears sticky adc_overrun
- adc_miso  in  1  ADC serial data, already synchronised to clk
- adc_csn  out  1  ADC chip select, active low
- adc_sclk  out  1  ADC serial clock, idles low
- adc_data_valid  out  1  one-cycle pulse, new sample
- adc_data_value  out  16  last completed sample, held between pulses
- adc_overrun  out  1  sticky: period tick while busy
- sample_count  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (async, rstn low): all state cleared immediately, including mid-frame.
  - adc_csn=1, adc_sclk=0, adc_data_valid=0, adc_data_value=0, adc_overrun=0, sample_count=0
  - period counter=0, state=IDLE
  - No partial frame is published.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 while enable=1, wrapping at the top.
  - The tick is the cycle on which the counter equals SAMPLE_PERIOD-1.
  - enable=0 holds the counter at 0; the first tick comes SAMPLE_PERIOD-1 cycles after enable rises.
- States: IDLE, SETUP, SHIFT, HOLD, PUBLISH.
- IDLE: on a tick, go to SETUP and assert adc_csn=0 starting the next cycle (T+1).
- SETUP: lasts CS_SETUP cycles with adc_sclk=0, then SHIFT.
- SHIFT:
  - A divider counts CLK_DIV cycles per half-period, then toggles adc_sclk.
  - On each low->high toggle, adc_miso is shifted into the LSB of a 16-bit shift register.
  - After FRAME_BITS rising edges and the final falling edge, go to HOLD.
  - Duration is exactly 2*FRAME_BITS*CLK_DIV cycles.
- HOLD: adc_csn=1, lasts CS_HOLD cycles, then PUBLISH.
- PUBLISH (one cycle):
  - adc_data_value <= shift register; adc_data_valid=1; sample_count increments.
  - Next state is IDLE.
- Latency: a tick at cycle T gives adc_data_valid high at T+1+CS_SETUP+2*FRAME_BITS*CLK_DIV+CS_HOLD. With defaults this is T+69.
- Spacing between valid pulses is guaranteed by requiring SAMPLE_PERIOD > frame length.
- Overrun:
  - A tick arriving in any state other than IDLE does not start a frame.
  - It sets adc_overrun=1 (sticky).
  - clear_overrun=1 clears it. If a tick-while-busy coincides with clear_overrun, set wins.
- enable deasserted mid-frame: the frame completes and publishes normally; no new frame starts.
- adc_data_valid is never high for two consecutive cycles and is 0 in every state except PUBLISH.
- adc_sclk is always 0 whenever adc_csn=1.

Test Plan:
- Defaults, ADC model drives 0xA5C3 MSB-first, enable rises at cycle 0:
  - adc_csn falls at cycle 100; exactly 16 SCLK rising edges, each with half-period 2.
  - Valid pulses for one cycle at cycle 168 with adc_data_value=0xA5C3; sample_count=1.
  - Next pulse at 268.
- Frames 0x0000, 0xFFFF, 0x8001 back to back: each value appears on its own pulse; adc_data_value holds between pulses; sample_count=3.
- enable dropped at cycle 120 (mid-SHIFT):
  - The frame still publishes at 168.
  - No further adc_csn activity over 500 cycles; the period counter stays at 0.
- SAMPLE_PERIOD=40 (shorter than the 69-cycle frame):
  - adc_overrun=1 after the second tick; frames still complete whole.
  - clear_overrun for one cycle gives adc_overrun=0 until the next busy tick.
- rstn pulsed low at cycle 130 (mid-frame):
  - Same cycle: adc_csn=1, adc_sclk=0, adc_data_value=0, valid=0.
  - No valid pulse for the aborted frame; sampling resumes from a counter value of 0.
- Force sample_count to 0xFFFF, then complete one frame: sample_count wraps to 0x0000; valid still pulses.
